bsg_blackparrot_link_cord_ctrl: RTL and testbench

Parametrised per-channel coordinate and traffic controller for the manycore links of a BlackParrot tile node. It supports any number of links, and each link's y-coordinate can be reprogrammed at runtime. Each channel counts its outstanding requests and gates new requests. A coordinate change is applied only after that channel has drained to zero outstanding requests, so in-flight responses never return to a stale coordinate. It sits between the tile's config source (tag/CSR) and the per-link request/response endpoints.

---
 rtl/bsg_blackparrot_link_cord_ctrl.sv | 116 +++++++++++
 tb/tb_bsg_blackparrot_link_cord_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_blackparrot_link_cord_ctrl.sv
// Per-link y-coordinate and outstanding-request controller for a BlackParrot tile.
// A coordinate change waits until its channel has no requests in flight, then commits.
module bsg_blackparrot_link_cord_ctrl #(
  parameter int unsigned num_chan_p       = 3,
  parameter int unsigned y_cord_width_p   = 7,
  parameter int unsigned max_out_p        = 16,
  parameter int unsigned default_y_cord_p = 0,
  localparam int unsigned chan_w_lp       = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 cfg_v_i,
  input  logic [chan_w_lp-1:0]                 cfg_chan_i,
  input  logic [y_cord_width_p-1:0]            cfg_y_cord_i,
  output logic                                 cfg_ready_o,
  input  logic [num_chan_p-1:0]                req_v_i,
  input  logic [num_chan_p-1:0]                link_ready_i,
  output logic [num_chan_p-1:0]                req_ready_o,
  input  logic [num_chan_p-1:0]                resp_v_i,
  output logic [num_chan_p*y_cord_width_p-1:0] my_y_cord_o,
  output logic [num_chan_p-1:0]                active_o,
  output logic [num_chan_p-1:0]                err_o,
  output logic                                 busy_o
);

  localparam int unsigned cnt_w_lp = $clog2(max_out_p + 1);

  typedef enum logic [1:0] {
    ST_UNCFG  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  logic [num_chan_p-1:0] w_chan_open;
  logic [num_chan_p-1:0] w_busy;
  logic                  w_cfg_ready;

  // Only channels that exist and are not mid-transition can take a new coordinate.
  always_comb begin
    w_cfg_ready = 1'b0;
    for (int unsigned c = 0; c < num_chan_p; c++) begin
      if (cfg_chan_i == chan_w_lp'(c)) w_cfg_ready = w_chan_open[c];
    end
  end

  assign cfg_ready_o = w_cfg_ready;
  assign busy_o      = |w_busy;

  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    state_e                    r_state;
    logic [cnt_w_lp-1:0]       r_cnt;
    logic [y_cord_width_p-1:0] r_cord;
    logic [y_cord_width_p-1:0] r_pend;
    logic                      r_err;
    logic                      w_req_ready;
    logic                      w_fire;
    logic                      w_cfg_fire;

    assign w_req_ready = (r_state == ST_ACTIVE) && link_ready_i[c]
                         && (r_cnt < cnt_w_lp'(max_out_p));
    assign w_fire      = req_v_i[c] & w_req_ready;
    assign w_cfg_fire  = cfg_v_i & w_cfg_ready & (cfg_chan_i == chan_w_lp'(c));

    assign w_chan_open[c] = (r_state == ST_UNCFG) || (r_state == ST_ACTIVE);
    assign w_busy[c]      = (r_state == ST_DRAIN) || (r_state == ST_COMMIT);
    assign req_ready_o[c] = w_req_ready;
    assign active_o[c]    = (r_state == ST_ACTIVE);
    assign err_o[c]       = r_err;
    assign my_y_cord_o[c*y_cord_width_p +: y_cord_width_p] = r_cord;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_state <= ST_UNCFG;
        r_cnt   <= '0;
        r_err   <= 1'b0;
        r_cord  <= y_cord_width_p'(default_y_cord_p);
        r_pend  <= '0;
      end else begin
        case (r_state)
          ST_UNCFG: begin
            if (w_cfg_fire) begin
              r_pend  <= cfg_y_cord_i;
              r_state <= ST_COMMIT;
            end
          end
          ST_ACTIVE: begin
            if (w_cfg_fire) begin
              r_pend  <= cfg_y_cord_i;
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (r_cnt == '0) r_state <= ST_COMMIT;
          end
          ST_COMMIT: begin
            r_cord  <= r_pend;
            r_state <= ST_ACTIVE;
          end
          default: r_state <= ST_UNCFG;
        endcase

        // Outstanding count; a response with nothing outstanding is a sticky error.
        if (r_state == ST_UNCFG) begin
          if (resp_v_i[c]) r_err <= 1'b1;
        end else if (w_fire && !resp_v_i[c]) begin
          r_cnt <= r_cnt + cnt_w_lp'(1);
        end else if (!w_fire && resp_v_i[c]) begin
          if (r_cnt == '0) r_err <= 1'b1;
          else             r_cnt <= r_cnt - cnt_w_lp'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bsg_blackparrot_link_cord_ctrl.sv
// Directed plus randomized bench for bsg_blackparrot_link_cord_ctrl against a
// transaction-level model of per-channel coordinates and outstanding counts.
module tb_bsg_blackparrot_link_cord_ctrl;

  localparam int NC = 3;
  localparam int YW = 7;
  localparam int MO = 16;

  localparam int M_UNCFG  = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_COMMIT = 3;

  logic              clk;
  logic              reset_i;
  logic              cfg_v;
  logic [1:0]        cfg_chan;
  logic [YW-1:0]     cfg_y;
  logic              cfg_ready;
  logic [NC-1:0]     req_v;
  logic [NC-1:0]     link_ready;
  logic [NC-1:0]     req_ready;
  logic [NC-1:0]     resp_v;
  logic [NC*YW-1:0]  cord;
  logic [NC-1:0]     active;
  logic [NC-1:0]     err;
  logic              busy;

  int errors = 0;
  int checks = 0;

  int m_mode [NC];
  int m_cnt  [NC];
  int m_cord [NC];
  int m_pend [NC];
  bit m_err  [NC];

  bsg_blackparrot_link_cord_ctrl #(
    .num_chan_p(NC), .y_cord_width_p(YW), .max_out_p(MO), .default_y_cord_p(0)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cfg_v_i(cfg_v), .cfg_chan_i(cfg_chan), .cfg_y_cord_i(cfg_y), .cfg_ready_o(cfg_ready),
    .req_v_i(req_v), .link_ready_i(link_ready), .req_ready_o(req_ready),
    .resp_v_i(resp_v), .my_y_cord_o(cord), .active_o(active), .err_o(err), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cord_of(input int c);
    logic [NC*YW-1:0] v;
    v = cord;
    return int'(v[c*YW +: YW]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_mode[c] = M_UNCFG; m_cnt[c] = 0; m_cord[c] = 0; m_pend[c] = 0; m_err[c] = 1'b0;
    end
  endtask

  // A config is accepted only by an existing channel that is unconfigured or idle-active.
  function automatic bit m_cfg_ready();
    if (int'(cfg_chan) >= NC) return 1'b0;
    return (m_mode[cfg_chan] == M_UNCFG) || (m_mode[cfg_chan] == M_ACTIVE);
  endfunction

  function automatic bit m_req_ready(input int c);
    return (m_mode[c] == M_ACTIVE) && link_ready[c] && (m_cnt[c] < MO);
  endfunction

  task automatic compare_all();
    logic [NC*YW-1:0] e_cord;
    logic [NC-1:0]    e_rr, e_act, e_err;
    bit               e_busy;
    e_busy = 1'b0;
    for (int c = 0; c < NC; c++) begin
      e_cord[c*YW +: YW] = YW'(m_cord[c]);
      e_rr[c]  = m_req_ready(c);
      e_act[c] = (m_mode[c] == M_ACTIVE);
      e_err[c] = m_err[c];
      if (m_mode[c] == M_DRAIN || m_mode[c] == M_COMMIT) e_busy = 1'b1;
    end
    chk("cfg_ready", 32'(cfg_ready), 32'(m_cfg_ready()));
    chk("req_ready", 32'(req_ready), 32'(e_rr));
    chk("my_y_cord", 32'(cord), 32'(e_cord));
    chk("active", 32'(active), 32'(e_act));
    chk("err", 32'(err), 32'(e_err));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic model_next();
    bit cr;
    bit rr [NC];
    if (reset_i) begin
      model_reset();
      return;
    end
    cr = m_cfg_ready();
    for (int c = 0; c < NC; c++) rr[c] = m_req_ready(c);
    for (int c = 0; c < NC; c++) begin
      int  old_cnt;
      int  net;
      bit  cfg_hit;
      old_cnt = m_cnt[c];
      cfg_hit = cfg_v && cr && (int'(cfg_chan) == c);
      if (m_mode[c] == M_UNCFG) begin
        if (resp_v[c]) m_err[c] = 1'b1;
      end else begin
        net = int'(req_v[c] && rr[c]) - int'(resp_v[c]);
        if (net < 0 && old_cnt == 0) m_err[c] = 1'b1;
        else                         m_cnt[c] = old_cnt + net;
      end
      case (m_mode[c])
        M_UNCFG:  if (cfg_hit) begin m_pend[c] = int'(cfg_y); m_mode[c] = M_COMMIT; end
        M_ACTIVE: if (cfg_hit) begin m_pend[c] = int'(cfg_y); m_mode[c] = M_DRAIN; end
        M_DRAIN:  if (old_cnt == 0) m_mode[c] = M_COMMIT;
        default:  begin m_cord[c] = m_pend[c]; m_mode[c] = M_ACTIVE; end
      endcase
    end
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic step();
    #1;
    compare_all();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int ch, input int y);
    cfg_v = 1'b1; cfg_chan = 2'(ch); cfg_y = YW'(y);
    step();
    cfg_v = 1'b0;
  endtask

  initial begin
    int fires;
    reset_i = 1'b1; cfg_v = 1'b0; cfg_chan = 2'd0; cfg_y = '0;
    req_v = '0; link_ready = '0; resp_v = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_i = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cord", 32'(cord), 32'd0);

    // Configure channel 1 from UNCFG: visible two cycles after the fire.
    link_ready = 3'b111;
    do_cfg(1, 5);
    chk("t1_cord1_mid", 32'(cord_of(1)), 32'd0);
    step();
    chk("t1_cord1", 32'(cord_of(1)), 32'd5);
    chk("t1_active", 32'(active), 32'b010);
    chk("t1_rr_others", 32'(req_ready & 3'b101), 32'd0);
    chk("t1_cord0", 32'(cord_of(0)), 32'd0);
    chk("t1_cord2", 32'(cord_of(2)), 32'd0);

    // Fill channel 0 to the outstanding limit.
    do_cfg(0, 3);
    step();
    req_v = 3'b001;
    fires = 0;
    repeat (20) begin
      #1;
      if (req_ready[0]) fires++;
      step();
    end
    chk("t2_fires", 32'(fires), 32'd16);
    chk("t2_rr0_full", 32'(req_ready[0]), 32'd0);
    resp_v = 3'b001;
    step();
    resp_v = 3'b000;
    #1;
    chk("t2_rr0_reopen", 32'(req_ready[0]), 32'd1);
    step();
    req_v = 3'b000;
    resp_v = 3'b001;
    repeat (13) step();
    resp_v = 3'b000;

    // Reconfigure channel 0 with 3 outstanding: drain, then commit.
    do_cfg(0, 9);
    #1;
    chk("t3_active0", 32'(active[0]), 32'd0);
    chk("t3_rr0", 32'(req_ready[0]), 32'd0);
    cfg_v = 1'b1; cfg_chan = 2'd0; cfg_y = 7'd20;
    #1;
    chk("t3_cfg_ready_drain", 32'(cfg_ready), 32'd0);
    step();
    cfg_v = 1'b0;
    resp_v = 3'b001;
    repeat (3) step();
    resp_v = 3'b000;
    step();
    chk("t3_cord0_commit", 32'(cord_of(0)), 32'd3);
    step();
    chk("t3_cord0_new", 32'(cord_of(0)), 32'd9);
    chk("t3_active0_back", 32'(active[0]), 32'd1);
    chk("t3_err0", 32'(err[0]), 32'd0);

    // Simultaneous fire and response on channel 2 leaves the count at 4.
    do_cfg(2, 7);
    step();
    req_v = 3'b100;
    repeat (4) step();
    resp_v = 3'b100;
    step();
    req_v = 3'b000;
    repeat (4) step();
    resp_v = 3'b000;
    chk("t4_err2_drained", 32'(err[2]), 32'd0);
    resp_v = 3'b100;
    step();
    resp_v = 3'b000;
    chk("t4_err2_extra", 32'(err[2]), 32'd1);

    // Underflow on channel 1 is sticky through later traffic.
    resp_v = 3'b010;
    step();
    resp_v = 3'b000;
    chk("t5_err1", 32'(err[1]), 32'd1);
    req_v = 3'b010;
    repeat (3) step();
    req_v = 3'b000;
    resp_v = 3'b010;
    repeat (2) step();
    resp_v = 3'b000;
    chk("t5_err1_sticky", 32'(err[1]), 32'd1);

    // Reset in the middle of a drain.
    req_v = 3'b001;
    repeat (2) step();
    req_v = 3'b000;
    do_cfg(0, 12);
    step();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    cfg_chan = 2'd0;
    #1;
    chk("t6_active", 32'(active), 32'd0);
    chk("t6_cord", 32'(cord), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rr", 32'(req_ready), 32'd0);
    chk("t6_cfg_ready", 32'(cfg_ready), 32'd1);
    resp_v = 3'b001;
    step();
    resp_v = 3'b000;
    chk("t6_err_after", 32'(err), 32'b001);

    // Out-of-range channel is never accepted.
    cfg_v = 1'b1; cfg_chan = 2'd3; cfg_y = 7'd1;
    #1;
    chk("t7_cfg_ready", 32'(cfg_ready), 32'd0);
    repeat (2) step();
    cfg_v = 1'b0;
    chk("t7_active", 32'(active), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    repeat (3000) begin
      reset_i    = ($urandom_range(299) == 0);
      cfg_v      = ($urandom_range(5) == 0);
      cfg_chan   = 2'($urandom_range(3));
      cfg_y      = YW'($urandom);
      req_v      = NC'($urandom);
      link_ready = NC'($urandom | $urandom);
      resp_v     = NC'($urandom & $urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
